// File: rtl/uart_tx_arbiter_if.sv
// Bundles the per-source AXI-Stream inputs, the UART-side stream and the grant status.
// master is the arbiter's view; slave is the view of the sources and the UART transmitter together.
interface uart_tx_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [8*NUM_SRC-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]   s_axis_tvalid;
  logic [NUM_SRC-1:0]   s_axis_tlast;
  logic [NUM_SRC-1:0]   s_axis_tready;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [2:0]           grant_id;
  logic                 busy;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, grant_id, busy
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges NUM_SRC byte streams onto one registered UART TX stream.
// Each grant covers one burst, optionally led by a source-ID header byte.
module uart_tx_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 16,
  parameter int ID_HEADER = 1,
  parameter int TIMEOUT   = 64
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.master bus
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HEADER = 2'd1;
  localparam logic [1:0] BURST  = 2'd2;

  logic [1:0]         state;
  logic [2:0]         grant_id;
  logic [2:0]         rr_ptr;
  logic [BW-1:0]      beat;
  logic [IW-1:0]      idle;
  logic [7:0]         m_tdata;
  logic               m_tvalid;

  logic               free;
  logic               any_req;
  logic [2:0]         winner;
  logic [3:0]         idx;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic [NUM_SRC-1:0] s_tready;
  logic               hs;
  logic               burst_end;

  assign free = !m_tvalid || bus.m_axis_tready;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = 4'(rr_ptr) + 4'(i);
      if (idx >= 4'(NUM_SRC)) idx = idx - 4'(NUM_SRC);
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!any_req && idx == 4'(j) && bus.s_axis_tvalid[j]) begin
          any_req = 1'b1;
          winner  = 3'(j);
        end
      end
    end
  end

  // Select the granted source's stream and form the per-source ready vector.
  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    s_tready = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (grant_id == 3'(j)) begin
        g_valid     = bus.s_axis_tvalid[j];
        g_last      = bus.s_axis_tlast[j];
        g_data      = bus.s_axis_tdata[8*j +: 8];
        s_tready[j] = (state == BURST) && free;
      end
    end
  end

  assign hs = (state == BURST) && free && g_valid;

  // Burst closes on tlast, on the MAX_BURST-th byte, or when the idle count reaches TIMEOUT.
  assign burst_end = (state == BURST) &&
                     ((hs && (g_last || beat == BW'(MAX_BURST - 1))) ||
                      (!hs && free && idle == IW'(TIMEOUT - 1)));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= 3'(NUM_SRC - 1);
      beat     <= '0;
      idle     <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
    end else begin
      if (m_tvalid && bus.m_axis_tready) m_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            beat     <= '0;
            idle     <= '0;
            state    <= (ID_HEADER != 0) ? HEADER : BURST;
          end
        end
        HEADER: begin
          if (free) begin
            m_tdata  <= {4'hA, 1'b0, grant_id};
            m_tvalid <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          if (hs) begin
            m_tdata  <= g_data;
            m_tvalid <= 1'b1;
            idle     <= '0;
            if (beat != BW'(MAX_BURST)) beat <= beat + 1'b1;
          end else if (free && !g_valid) begin
            if (idle != IW'(TIMEOUT)) idle <= idle + 1'b1;
          end
          if (burst_end) begin
            rr_ptr <= grant_id;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_axis_tready = s_tready;
  assign bus.m_axis_tdata  = m_tdata;
  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.grant_id      = grant_id;
  assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected UART bytes, a negedge monitor pops and compares.
module tb_uart_tx_arbiter;
  localparam int NUM_SRC   = 4;
  localparam int MAX_BURST = 16;
  localparam int TIMEOUT   = 64;

  typedef struct packed {
    logic [7:0] data;
    logic       hdr;
    logic [2:0] src;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

  uart_tx_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .MAX_BURST(MAX_BURST),
    .ID_HEADER(1),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   rdy1_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_hdr(input int src);
    exp_q.push_back('{data: 8'hA0 | 8'(src), hdr: 1'b1, src: 3'(src)});
  endtask

  task automatic push_data(input logic [7:0] first, input logic [7:0] step, input int len);
    for (int k = 0; k < len; k++)
      exp_q.push_back('{data: first + 8'(k) * step, hdr: 1'b0, src: 3'd0});
  endtask

  // Drives one source; returns early (without error) if reset is asserted mid-transfer.
  task automatic send(input int src, input logic [7:0] first, input logic [7:0] step,
                      input int len, input bit last);
    bit hs_seen;
    bit stop;
    int wait_n;
    stop = 1'b0;
    for (int k = 0; k < len && !stop; k++) begin
      bus.s_axis_tdata[8*src +: 8] = first + 8'(k) * step;
      bus.s_axis_tvalid[src]       = 1'b1;
      bus.s_axis_tlast[src]        = last && (k == len - 1);
      wait_n = 0;
      forever begin
        @(negedge clk);
        hs_seen = bus.s_axis_tready[src] && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
          stop = 1'b1;
          break;
        end
        if (hs_seen) break;
        wait_n++;
        if (wait_n > 300) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: src %0d byte %0d never accepted", src, k);
          stop = 1'b1;
          break;
        end
      end
    end
    bus.s_axis_tvalid[src] = 1'b0;
    bus.s_axis_tlast[src]  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy || bus.m_axis_tvalid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_pending_bytes"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.m_axis_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("m_tdata", 32'(bus.m_axis_tdata), 32'(mon_e.data));
        if (mon_e.hdr) check("hdr_grant_id", 32'(bus.grant_id), 32'(mon_e.src));
      end
    end
    if (bus.s_axis_tready[1]) rdy1_cnt++;
  end

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
    rst = 1'b0;

    // Single tlast burst from src1.
    rdy1_cnt = 0;
    push_hdr(1);
    push_data(8'h11, 8'h11, 3);
    send(1, 8'h11, 8'h11, 3, 1'b1);
    drain("t1");
    check("t1_tready1_cycles", 32'(rdy1_cnt), 32'd3);

    // src0 and src2 alternate 2-byte bursts.
    do_reset();
    push_hdr(0); push_data(8'h01, 8'h01, 2);
    push_hdr(2); push_data(8'h21, 8'h01, 2);
    push_hdr(0); push_data(8'h03, 8'h01, 2);
    push_hdr(2); push_data(8'h23, 8'h01, 2);
    fork
      begin
        send(0, 8'h01, 8'h01, 2, 1'b1);
        send(0, 8'h03, 8'h01, 2, 1'b1);
      end
      begin
        send(2, 8'h21, 8'h01, 2, 1'b1);
        send(2, 8'h23, 8'h01, 2, 1'b1);
      end
    join
    drain("t2");

    // 20 bytes without tlast: split at MAX_BURST, tail ends by timeout.
    push_hdr(3); push_data(8'h40, 8'h01, MAX_BURST);
    push_hdr(3); push_data(8'h40 + 8'(MAX_BURST), 8'h01, 20 - MAX_BURST);
    send(3, 8'h40, 8'h01, 20, 1'b0);
    drain("t3");

    // src0 goes idle after one byte; grant revoked exactly at TIMEOUT, src1 follows.
    push_hdr(0); push_data(8'h55, 8'h01, 1);
    push_hdr(1); push_data(8'h66, 8'h01, 2);
    fork
      begin
        send(0, 8'h55, 8'h01, 1, 1'b0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("t4_busy_before_timeout", 32'(bus.busy), 32'd1);
        check("t4_grant_before_timeout", 32'(bus.grant_id), 32'd0);
        @(posedge clk);
        #1;
        check("t4_busy_at_timeout", 32'(bus.busy), 32'd0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        send(1, 8'h66, 8'h01, 2, 1'b1);
      end
    join
    drain("t4");

    // Output back-pressure for 10 cycles mid-burst.
    push_hdr(2); push_data(8'h70, 8'h01, 6);
    fork
      send(2, 8'h70, 8'h01, 6, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.m_axis_tready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("t5_stall_m_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
          check("t5_stall_s_tready", 32'(bus.s_axis_tready), 32'd0);
          check("t5_stall_m_tdata", 32'(bus.m_axis_tdata), 32'(exp_q[0].data));
        end
        @(posedge clk);
        #1;
        bus.m_axis_tready = 1'b1;
      end
    join
    drain("t5");

    // Reset while a byte is held in the output register.
    push_hdr(1); push_data(8'h80, 8'h01, 8);
    fork
      send(1, 8'h80, 8'h01, 8, 1'b1);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t6_pre_rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("t6_rst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_grant_id", 32'(bus.grant_id), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    push_hdr(0); push_data(8'hA5, 8'h01, 2);
    push_hdr(1); push_data(8'hB5, 8'h01, 2);
    fork
      send(0, 8'hA5, 8'h01, 2, 1'b1);
      send(1, 8'hB5, 8'h01, 2, 1'b1);
    join
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
